// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl
// Brief    : Memory-stage load/store controller with request/ready/done
//            handshake, DataMemStall generation and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] AddrM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              DataMemStall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              mem_done,
    output logic              err_align,
    output logic              err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // The counter is compared before its increment, so the last WAIT cycle
    // is the one in which it holds TIMEOUT-1 and would step to TIMEOUT.
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_align_q;
    logic                err_timeout_q;
    logic                w_req;

    assign w_req = MemReadM | MemWriteM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            wr_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            err_align_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_req) begin
                        addr_q  <= AddrM;
                        wdata_q <= WriteDataM;
                        wr_q    <= MemWriteM;
                        if (AddrM[0]) begin
                            err_align_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // A done pulse alongside ready is ignored here.
                    if (mem_ready) begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (mem_done) begin
                        if (!wr_q) begin
                            rdata_q <= mem_rdata;
                        end
                        state_q <= S_DONE;
                    end else if (cnt_q == C_CNT_LAST) begin
                        err_timeout_q <= 1'b1;
                        if (!wr_q) begin
                            rdata_q <= '0;
                        end
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign DataMemStall = ((state_q == S_IDLE) && w_req) ||
                          (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign mem_en       = (state_q == S_ISSUE);
    assign mem_wr       = wr_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign ReadDataM    = rdata_q;
    assign err_align    = err_align_q;
    assign err_timeout  = err_timeout_q;

endmodule
`default_nettype wire
